// File: rtl/delay_line_pkg.sv
// ----------------------------------------------------------------------------
// delay_line_pkg
//   Shared helpers for the delay_line block.
//   clamp_int : saturate an integer into [lo, hi]; maps the requested delay
//               onto the range the line can actually realise.
// ----------------------------------------------------------------------------
package delay_line_pkg;

    function automatic int clamp_int(input int v, input int lo, input int hi);
        if (v < lo) begin
            return lo;
        end
        if (v > hi) begin
            return hi;
        end
        return v;
    endfunction

endpackage

// File: rtl/delay_line_ram.sv
// ----------------------------------------------------------------------------
// delay_line_ram
//   DEPTH-1 entry ring storage for delay_line. One synchronous write port and
//   one asynchronous read port. The read address trails the write pointer by
//   (delay-1) entries, so the word read during an accepting edge is the sample
//   accepted delay-1 enabled edges earlier.
//
// Ports
//   ck      in   clock
//   rst     in   synchronous active-high reset (write pointer only)
//   we      in   write enable; also advances the write pointer
//   wdata   in   WIDTH  sample to store
//   delay   in   AW+1   active delay (1..DEPTH); 1 is never read by the top
//   rdata   out  WIDTH  sample accepted delay-1 writes ago (combinational)
// ----------------------------------------------------------------------------
module delay_line_ram #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16
) (
    input  logic                     ck,
    input  logic                     rst,
    input  logic                     we,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH):0]   delay,
    output logic [WIDTH-1:0]         rdata
);

    localparam int N  = DEPTH - 1;
    localparam int PW = $clog2(DEPTH);

    // NOTE: storage carries no reset; stale words are harmless because the top
    // zeroes its output until the line has refilled with genuine samples.
    logic [WIDTH-1:0] mem [N];

    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] wr_ptr_d;
    logic [PW-1:0] rd_addr;
    int            rd_int;

    always_comb begin
        // NOTE: every variable driven here gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        wr_ptr_d = wr_ptr_q;
        if (we) begin
            wr_ptr_d = (wr_ptr_q == PW'(N - 1)) ? '0 : wr_ptr_q + 1'b1;
        end

        // Distance delay-1 behind the next write slot, wrapped modulo N.
        // At the maximum distance N this lands on the slot about to be
        // overwritten, which still holds the oldest sample this edge.
        rd_int = int'(wr_ptr_q) - (int'(delay) - 1);
        if (rd_int < 0) begin
            rd_int = rd_int + N;
        end
        rd_addr = PW'(rd_int);
    end

    assign rdata = mem[rd_addr];

    always_ff @(posedge ck) begin
        // NOTE: state is updated with non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            wr_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
        end
        if (we) begin
            mem[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/delay_line.sv
// ----------------------------------------------------------------------------
// delay_line
//   Clock-enabled WIDTH-bit delay line with a run-time selectable delay of
//   1..DEPTH accepted samples. out_valid marks that the line has refilled
//   with genuine data since the last restart (reset, clear or delay change);
//   until then out is held at zero.
//
// Ports
//   ck         in   clock
//   rst        in   synchronous active-high reset
//   en         in   sample enable; accepts `in` and advances the line
//   clr        in   synchronous clear / restart fill
//   delay      in   AW+1   requested delay (clamped to 1..DEPTH)
//   in         in   WIDTH  input sample
//   out        out  WIDTH  delayed sample (registered)
//   out_valid  out  1      out holds a genuine sample
// ----------------------------------------------------------------------------
module delay_line
    import delay_line_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16
) (
    input  logic                     ck,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     clr,
    input  logic [$clog2(DEPTH):0]   delay,
    input  logic [WIDTH-1:0]         in,
    output logic [WIDTH-1:0]         out,
    output logic                     out_valid
);

    localparam int AW = $clog2(DEPTH);
    localparam int DW = AW + 1;

    logic [DW-1:0]    deff;
    logic             restart;
    logic [DW-1:0]    fill_inc;
    logic             valid_nxt;
    logic [WIDTH-1:0] sample;
    logic [WIDTH-1:0] ram_rdata;
    logic             ram_we;

    logic [DW-1:0]    cur_delay_q, cur_delay_d;
    logic [DW-1:0]    fill_q, fill_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             valid_q, valid_d;

    delay_line_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ram (
        .ck    (ck),
        .rst   (rst),
        .we    (ram_we),
        .wdata (in),
        .delay (cur_delay_q),
        .rdata (ram_rdata)
    );

    always_comb begin
        deff    = DW'(clamp_int(int'(delay), 1, DEPTH));
        restart = rst | clr | (deff != cur_delay_q);

        fill_inc  = fill_q + DW'(1);
        valid_nxt = (fill_inc >= cur_delay_q);
        // A one-stage line is just the output register itself.
        sample    = (cur_delay_q == DW'(1)) ? in : ram_rdata;

        cur_delay_d = cur_delay_q;
        fill_d      = fill_q;
        out_d       = out_q;
        valid_d     = valid_q;

        if (restart) begin
            cur_delay_d = deff;
            fill_d      = '0;
            out_d       = '0;
            valid_d     = 1'b0;
        end else if (en) begin
            fill_d  = (fill_inc > cur_delay_q) ? cur_delay_q : fill_inc;
            valid_d = valid_nxt;
            out_d   = valid_nxt ? sample : '0;
        end
    end

    // The sample offered on a restart edge is discarded, never stored.
    assign ram_we = en & ~restart;

    always_ff @(posedge ck) begin
        if (rst) begin
            cur_delay_q <= deff;
            fill_q      <= '0;
            out_q       <= '0;
            valid_q     <= 1'b0;
        end else begin
            cur_delay_q <= cur_delay_d;
            fill_q      <= fill_d;
            out_q       <= out_d;
            valid_q     <= valid_d;
        end
    end

    assign out       = out_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_delay_line.sv
// ----------------------------------------------------------------------------
// tb_delay_line
//   Self-checking bench for delay_line (WIDTH=16, DEPTH=16). A queue-based
//   reference model tracks the samples accepted since the last restart; the
//   expected output is simply the sample Deff-1 entries back from the newest.
// ----------------------------------------------------------------------------
module tb_delay_line;

    localparam int WIDTH = 16;
    localparam int DEPTH = 16;

    logic             ck;
    logic             rst;
    logic             en;
    logic             clr;
    logic [4:0]       delay;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;

    delay_line #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .ck        (ck),
        .rst       (rst),
        .en        (en),
        .clr       (clr),
        .delay     (delay),
        .in        (din),
        .out       (dout),
        .out_valid (dout_valid)
    );

    initial ck = 1'b0;
    always #5 ck = ~ck;

    int n_cmp = 0;
    int n_mis = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int               m_cur;
    logic [WIDTH-1:0] m_q[$];
    logic [WIDTH-1:0] m_out;
    logic             m_vld;

    function automatic int eff_delay(input int d);
        if (d == 0) return 1;
        if (d > DEPTH) return DEPTH;
        return d;
    endfunction

    function automatic void model_edge(input logic r, input logic c, input logic e,
                                       input int d, input logic [WIDTH-1:0] x);
        int de;
        de = eff_delay(d);
        if (r || c || de != m_cur) begin
            m_cur = de;
            m_q.delete();
            m_out = '0;
            m_vld = 1'b0;
        end else if (e) begin
            m_q.push_back(x);
            if (m_q.size() > DEPTH) void'(m_q.pop_front());
            if (m_q.size() >= m_cur) begin
                m_out = m_q[m_q.size() - m_cur];
                m_vld = 1'b1;
            end else begin
                m_out = '0;
                m_vld = 1'b0;
            end
        end
    endfunction

    // One clock: apply inputs, advance model, compare against it.
    task automatic drive(input logic r, input logic c, input logic e,
                         input logic [4:0] d, input logic [WIDTH-1:0] x);
        rst   = r;
        clr   = c;
        en    = e;
        delay = d;
        din   = x;
        @(posedge ck);
        model_edge(r, c, e, int'(d), x);
        #1;
        check("model_out", dout, m_out);
        check("model_vld", dout_valid, m_vld);
    endtask

    task automatic marker_test(input logic [4:0] d, input int deff_exp);
        int first;
        int seen;
        first = -1;
        seen  = 0;
        drive(1'b0, 1'b1, 1'b1, d, '0);
        repeat (deff_exp) drive(1'b0, 1'b0, 1'b1, d, '0);
        drive(1'b0, 1'b0, 1'b1, d, 16'hFFFF);
        if (dout == 16'hFFFF) begin
            first = 1;
            seen++;
        end
        for (int i = 2; i <= deff_exp + 3; i++) begin
            drive(1'b0, 1'b0, 1'b1, d, '0);
            if (dout == 16'hFFFF) begin
                if (first < 0) first = i;
                seen++;
            end
        end
        check("mark_lat", first, deff_exp);
        check("mark_cnt", seen, 1);
    endtask

    initial begin
        logic [WIDTH-1:0] prev;
        int               k;
        rst = 1'b1; clr = 1'b0; en = 1'b0; delay = 5'd4; din = '0;
        m_cur = 4; m_out = '0; m_vld = 1'b0;

        // Reset values
        drive(1'b1, 1'b0, 1'b1, 5'd4, 16'h1234);
        check("rst_out", dout, 0);
        check("rst_vld", dout_valid, 0);

        // delay=4 stream 1,2,3,...
        for (int i = 1; i <= 10; i++) begin
            drive(1'b0, 1'b0, 1'b1, 5'd4, 16'(i));
            check("d4_out", dout, (i >= 4) ? i - 3 : 0);
            check("d4_vld", dout_valid, (i >= 4) ? 1 : 0);
        end

        // en toggling after a clear
        drive(1'b0, 1'b1, 1'b1, 5'd4, 16'h00AA);
        check("clr_out", dout, 0);
        check("clr_vld", dout_valid, 0);
        k = 0;
        for (int c = 1; c <= 12; c++) begin
            prev = dout;
            if (c % 2 == 1) begin
                k++;
                drive(1'b0, 1'b0, 1'b1, 5'd4, 16'(k));
            end else begin
                drive(1'b0, 1'b0, 1'b0, 5'd4, 16'hDEAD);
                check("gap_hold", dout, prev);
            end
            if (c == 6) check("tog_c6", dout, 0);
            if (c == 7) begin
                check("tog_c7_out", dout, 1);
                check("tog_c7_vld", dout_valid, 1);
            end
        end

        // Single-cycle markers at boundary delays
        marker_test(5'd1, 1);
        marker_test(5'd16, 16);
        marker_test(5'd0, 1);
        marker_test(5'd31, 16);

        // Delay switch mid-stream
        drive(1'b0, 1'b1, 1'b1, 5'd4, '0);
        for (int i = 1; i <= 6; i++) drive(1'b0, 1'b0, 1'b1, 5'd4, 16'(50 + i));
        check("pre_sw_vld", dout_valid, 1);
        drive(1'b0, 1'b0, 1'b1, 5'd2, 16'h0099);
        check("sw_out", dout, 0);
        check("sw_vld", dout_valid, 0);
        drive(1'b0, 1'b0, 1'b1, 5'd2, 16'd100);
        check("sw1_vld", dout_valid, 0);
        drive(1'b0, 1'b0, 1'b1, 5'd2, 16'd101);
        check("sw2_out", dout, 100);
        check("sw2_vld", dout_valid, 1);

        // clr mid-stream, then rst+clr together
        drive(1'b0, 1'b1, 1'b1, 5'd2, 16'h0077);
        check("mclr_vld", dout_valid, 0);
        drive(1'b0, 1'b0, 1'b1, 5'd2, 16'd200);
        drive(1'b0, 1'b0, 1'b1, 5'd2, 16'd201);
        check("mclr_out", dout, 200);
        drive(1'b1, 1'b1, 1'b1, 5'd2, 16'h0055);
        check("rc_out", dout, 0);
        check("rc_vld", dout_valid, 0);

        // Random stimulus against the model
        begin
            logic [4:0] d;
            d = 5'd4;
            for (int i = 0; i < 10000; i++) begin
                if ($urandom_range(63) == 0) d = 5'($urandom_range(31));
                drive($urandom_range(511) == 0, $urandom_range(127) == 0,
                      1'($urandom_range(1)), d, 16'($urandom));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
